// File: rtl/divider_pkg.sv
// Shared definitions for the pipelined divider: operand mode encoding and
// the accept-to-result latency of the pipeline.
package divider_pkg;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // One capture register, one register per quotient bit, one output register.
    function automatic int divmod_latency(input int dividend_width);
        return dividend_width + 2;
    endfunction

endpackage

// File: rtl/pipelined_divmod_if.sv
// Request/result handshake bundle for pipelined_divmod.
// The dbz flag exists only when PIPELINED_DIVMOD_DBZ_EN is defined.
interface pipelined_divmod_if #(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int TAG_WIDTH      = 6
);
    import divider_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic                      in_signed;
    logic [TAG_WIDTH-1:0]      in_tag;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;

    logic                      out_valid;
    logic                      out_ready;
    logic [TAG_WIDTH-1:0]      out_tag;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVIDEND_WIDTH-1:0] remainder;
    logic                      overflow;
`ifdef PIPELINED_DIVMOD_DBZ_EN
    logic                      dbz;

    modport master (
        output in_valid, in_signed, in_tag, dividend, divisor, out_ready,
        input  in_ready, out_valid, out_tag, quotient, remainder, overflow, dbz
    );
    modport slave (
        input  in_valid, in_signed, in_tag, dividend, divisor, out_ready,
        output in_ready, out_valid, out_tag, quotient, remainder, overflow, dbz
    );
`else
    modport master (
        output in_valid, in_signed, in_tag, dividend, divisor, out_ready,
        input  in_ready, out_valid, out_tag, quotient, remainder, overflow
    );
    modport slave (
        input  in_valid, in_signed, in_tag, dividend, divisor, out_ready,
        output in_ready, out_valid, out_tag, quotient, remainder, overflow
    );
`endif

endinterface

// File: rtl/divmod_stage.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor magnitude, keep the
// difference when it is non-negative and record the quotient bit.
// The whole stage holds its contents while en is low.
module divmod_stage #(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int SB_WIDTH       = 9
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic                                          en,
    input  logic                                          vld_i,
    input  logic [DIVIDEND_WIDTH+DIVISOR_WIDTH:0]         rem_i,
    input  logic [DIVIDEND_WIDTH-1:0]                     dq_i,
    input  logic [DIVISOR_WIDTH-1:0]                      dvs_i,
    input  logic [SB_WIDTH-1:0]                           sb_i,
    output logic                                          vld_o,
    output logic [DIVIDEND_WIDTH+DIVISOR_WIDTH:0]         rem_o,
    output logic [DIVIDEND_WIDTH-1:0]                     dq_o,
    output logic [DIVISOR_WIDTH-1:0]                      dvs_o,
    output logic [SB_WIDTH-1:0]                           sb_o
);
    import divider_pkg::*;

    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;
    localparam int IW = DIVIDEND_WIDTH + DIVISOR_WIDTH + 1;

    logic signed [IW-1:0] rem_shift;
    logic signed [IW-1:0] trial;
    logic                 qbit;
    logic                 unused_rem_msb;

    logic          vld_d, vld_q;
    logic [IW-1:0] rem_d, rem_q;
    logic [DW-1:0] dq_d,  dq_q;
    logic [VW-1:0] dvs_d, dvs_q;
    logic [SB_WIDTH-1:0] sb_d, sb_q;

    // The partial remainder is always below the divisor, so its top bit is never set.
    assign unused_rem_msb = rem_i[IW-1];

    // Shift/trial-subtract and next-state selection with stall hold.
    always_comb begin
        rem_shift = $signed({rem_i[IW-2:0], dq_i[DW-1]});
        trial     = rem_shift - $signed({{(IW-VW){1'b0}}, dvs_i});
        qbit      = ~trial[IW-1];

        vld_d = vld_q;
        rem_d = rem_q;
        dq_d  = dq_q;
        dvs_d = dvs_q;
        sb_d  = sb_q;
        if (en) begin
            vld_d = vld_i;
            if (vld_i) begin
                rem_d = qbit ? trial : rem_shift;
                dq_d  = {dq_i[DW-2:0], qbit};
                dvs_d = dvs_i;
                sb_d  = sb_i;
            end
        end
    end

    // Valid bit is the only reset state in the stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Data registers carry no reset; they are qualified by the valid bit.
    always_ff @(posedge clock) begin
        rem_q <= rem_d;
        dq_q  <= dq_d;
        dvs_q <= dvs_d;
        sb_q  <= sb_d;
    end

    assign vld_o = vld_q;
    assign rem_o = rem_q;
    assign dq_o  = dq_q;
    assign dvs_o = dvs_q;
    assign sb_o  = sb_q;

endmodule

// File: rtl/pipelined_divmod.sv
// Fully pipelined truncating divider with remainder, signed or unsigned per
// request. Capture stage forms operand magnitudes and sign flags, one
// divmod_stage per quotient bit, then a sign-correcting output register.
// The pipeline stalls globally whenever a result is held at the output.
// Optional feature: define PIPELINED_DIVMOD_DBZ_EN to add the dbz flag and
// force divide-by-zero results (quotient all ones, remainder = dividend).
module pipelined_divmod
    import divider_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int TAG_WIDTH      = 6
) (
    input logic               clock,
    input logic               reset_n,
    pipelined_divmod_if.slave io
);

    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;
    localparam int TW = TAG_WIDTH;
    localparam int IW = DW + VW + 1;

    // Sideband layout, LSB first: overflow, remainder-negative,
    // quotient-negative, [dbz], then the tag in the top bits.
    localparam int SB_OVF  = 0;
    localparam int SB_NEGR = 1;
    localparam int SB_NEGQ = 2;
`ifdef PIPELINED_DIVMOD_DBZ_EN
    localparam int SB_DBZ  = 3;
    localparam int SBW     = TW + 4;
`else
    localparam int SBW     = TW + 3;
`endif

    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    function automatic logic [DW-1:0] apply_sign(input logic [DW-1:0] mag, input logic neg);
        return neg ? ({DW{1'b0}} - mag) : mag;
    endfunction

    logic          en;
    logic          dvd_neg, dvs_neg, is_ovf;
    logic [DW-1:0] dvd_abs;
    logic [VW-1:0] dvs_abs;
    logic [SBW-1:0] sb_in;

    logic           cap_vld_d, cap_vld_q;
    logic [DW-1:0]  cap_dq_d,  cap_dq_q;
    logic [VW-1:0]  cap_dvs_d, cap_dvs_q;
    logic [SBW-1:0] cap_sb_d,  cap_sb_q;

    logic           vld_c [0:DW];
    logic [IW-1:0]  rem_c [0:DW];
    logic [DW-1:0]  dq_c  [0:DW];
    logic [VW-1:0]  dvs_c [0:DW];
    logic [SBW-1:0] sb_c  [0:DW];
    logic [SBW-1:0] sb_last;
    logic           unused_tail;

    logic          out_vld_d, out_vld_q;
    logic [DW-1:0] quo_d, quo_q;
    logic [DW-1:0] rem_d, rem_q;
    logic [TW-1:0] tag_d, tag_q;
    logic          ovf_d, ovf_q;
`ifdef PIPELINED_DIVMOD_DBZ_EN
    logic          dbz_d, dbz_q;
`endif

    assign io.in_ready = !(out_vld_q && !io.out_ready);
    assign en          = io.in_ready;

    // Operand magnitudes, sign flags and the overflow/zero-divisor flags.
    always_comb begin
        dvd_neg = (io.in_signed == MODE_SIGNED) && io.dividend[DW-1];
        dvs_neg = (io.in_signed == MODE_SIGNED) && io.divisor[VW-1];
        dvd_abs = dvd_neg ? ({DW{1'b0}} - io.dividend) : io.dividend;
        dvs_abs = dvs_neg ? ({VW{1'b0}} - io.divisor) : io.divisor;
        is_ovf  = (io.in_signed == MODE_SIGNED) && (io.dividend == MOST_NEG) &&
                  (io.divisor == {VW{1'b1}});
`ifdef PIPELINED_DIVMOD_DBZ_EN
        sb_in = {io.in_tag, (io.divisor == {VW{1'b0}}), dvd_neg ^ dvs_neg, dvd_neg, is_ovf};
`else
        sb_in = {io.in_tag, dvd_neg ^ dvs_neg, dvd_neg, is_ovf};
`endif
    end

    // Capture-stage next state: load on accept, hold while stalled.
    always_comb begin
        cap_vld_d = cap_vld_q;
        cap_dq_d  = cap_dq_q;
        cap_dvs_d = cap_dvs_q;
        cap_sb_d  = cap_sb_q;
        if (en) begin
            cap_vld_d = io.in_valid;
            if (io.in_valid) begin
                cap_dq_d  = dvd_abs;
                cap_dvs_d = dvs_abs;
                cap_sb_d  = sb_in;
            end
        end
    end

    // Capture-stage valid bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_vld_q <= 1'b0;
        end else begin
            cap_vld_q <= cap_vld_d;
        end
    end

    // Capture-stage data, not reset.
    always_ff @(posedge clock) begin
        cap_dq_q  <= cap_dq_d;
        cap_dvs_q <= cap_dvs_d;
        cap_sb_q  <= cap_sb_d;
    end

    assign vld_c[0] = cap_vld_q;
    assign rem_c[0] = {IW{1'b0}};
    assign dq_c[0]  = cap_dq_q;
    assign dvs_c[0] = cap_dvs_q;
    assign sb_c[0]  = cap_sb_q;

    for (genvar g = 0; g < DW; g++) begin : g_stage
        divmod_stage #(
            .DIVIDEND_WIDTH (DW),
            .DIVISOR_WIDTH  (VW),
            .SB_WIDTH       (SBW)
        ) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .en      (en),
            .vld_i   (vld_c[g]),
            .rem_i   (rem_c[g]),
            .dq_i    (dq_c[g]),
            .dvs_i   (dvs_c[g]),
            .sb_i    (sb_c[g]),
            .vld_o   (vld_c[g+1]),
            .rem_o   (rem_c[g+1]),
            .dq_o    (dq_c[g+1]),
            .dvs_o   (dvs_c[g+1]),
            .sb_o    (sb_c[g+1])
        );
    end

    assign sb_last     = sb_c[DW];
    assign unused_tail = ^{rem_c[DW][IW-1:DW], dvs_c[DW]};

    // Output register: restore signs and apply the special-case overrides.
    always_comb begin
        out_vld_d = out_vld_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        tag_d     = tag_q;
        ovf_d     = ovf_q;
`ifdef PIPELINED_DIVMOD_DBZ_EN
        dbz_d     = dbz_q;
`endif
        if (en) begin
            out_vld_d = vld_c[DW];
            if (vld_c[DW]) begin
                quo_d = apply_sign(dq_c[DW], sb_last[SB_NEGQ]);
                rem_d = apply_sign(rem_c[DW][DW-1:0], sb_last[SB_NEGR]);
                tag_d = sb_last[SBW-1 -: TW];
                ovf_d = sb_last[SB_OVF];
                if (sb_last[SB_OVF]) begin
                    quo_d = MOST_NEG;
                    rem_d = {DW{1'b0}};
                end
`ifdef PIPELINED_DIVMOD_DBZ_EN
                dbz_d = sb_last[SB_DBZ];
                if (sb_last[SB_DBZ]) begin
                    quo_d = {DW{1'b1}};
                end
`endif
            end
        end
    end

    // Output registers, all cleared by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_vld_q <= 1'b0;
            quo_q     <= {DW{1'b0}};
            rem_q     <= {DW{1'b0}};
            tag_q     <= {TW{1'b0}};
            ovf_q     <= 1'b0;
`ifdef PIPELINED_DIVMOD_DBZ_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            out_vld_q <= out_vld_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            tag_q     <= tag_d;
            ovf_q     <= ovf_d;
`ifdef PIPELINED_DIVMOD_DBZ_EN
            dbz_q     <= dbz_d;
`endif
        end
    end

    assign io.out_valid = out_vld_q;
    assign io.quotient  = quo_q;
    assign io.remainder = rem_q;
    assign io.out_tag   = tag_q;
    assign io.overflow  = ovf_q;
`ifdef PIPELINED_DIVMOD_DBZ_EN
    assign io.dbz       = dbz_q;
`endif

endmodule

// File: doc/pipelined_divmod.md
PIPELINED_DIVMOD -- requirements
Module: pipelined_divmod

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 16: dividend, quotient and remainder width, legal range 4..32.
REQ-002 SHALL have parameter DIVISOR_WIDTH, default 8: divisor width, legal range 2..DIVIDEND_WIDTH.
REQ-003 SHALL have parameter TAG_WIDTH, default 6: opaque tag width.
REQ-004 SHALL have port: clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: in_valid  in  1  request present.
REQ-007 SHALL have port: in_ready  out  1  request accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port: in_signed  in  1  operands two's-complement (1) or unsigned (0).
REQ-009 SHALL have ports: in_tag  in  TAG_WIDTH  / dividend  in  DIVIDEND_WIDTH  / divisor  in  DIVISOR_WIDTH.
REQ-010 SHALL have port: out_valid  out  1  result present.
REQ-011 SHALL have port: out_ready  in  1  consumer accepts result.
REQ-012 SHALL have ports: out_tag  out  TAG_WIDTH  / quotient  out  DIVIDEND_WIDTH  / remainder  out  DIVIDEND_WIDTH  / overflow  out  1.

Function
REQ-013 SHALL compute truncating division: quotient rounds toward zero; remainder carries the dividend's sign; dividend == quotient*divisor + remainder.
REQ-014 SHALL, in signed mode, treat both operands as two's-complement, including a negative divisor.
REQ-015 SHALL, in unsigned mode, treat both operands as unsigned, with the full range of each.
REQ-016 SHALL be organised as one capture stage (absolute values, sign flags), DIVIDEND_WIDTH restoring-iteration stages, and one sign-correction output register.
REQ-017 SHALL have a latency from accept to out_valid of DIVIDEND_WIDTH+2 cycles when unstalled.
REQ-018 SHALL have a throughput of one request per cycle.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready), combinational.
REQ-020 SHALL freeze all stage registers while in_ready is low, so the pipeline stalls globally with no data loss or duplication.
REQ-021 SHALL hold out_valid, out_tag, quotient, remainder and overflow stable while out_valid is high and out_ready is low.
REQ-022 SHALL propagate in_tag unchanged, so results emerge in request order.
REQ-023 SHALL handle signed overflow (dividend == most-negative, divisor == -1) as: quotient = most-negative value, remainder = 0, overflow = 1.
REQ-024 SHALL drive overflow = 0 for every other case.
REQ-025 SHALL size internal iteration arithmetic at DIVIDEND_WIDTH+DIVISOR_WIDTH+1 bits so no intermediate wraps.
REQ-026 SHALL sample in_ready low and in_valid high as no acceptance; the requester holds the request.

Reset
REQ-027 SHALL, on reset_n low, immediately clear every stage valid bit and out_valid.
REQ-028 SHALL, on reset_n low, drive quotient, remainder, out_tag and overflow to 0.
REQ-029 SHALL discard in-flight requests on reset mid-operation; no result for them appears after release.
REQ-030 SHALL drive in_ready = 1 during and after reset.
REQ-031 SHALL allow internal data registers to be non-reset; only valid bits and outputs are reset.

Configuration
REQ-032 SHALL, with PIPELINED_DIVMOD_DBZ_EN defined, add port dbz (out, 1, reset 0).
REQ-033 SHALL, with PIPELINED_DIVMOD_DBZ_EN defined, force divisor == 0 results to quotient = all ones, remainder = dividend, dbz = 1, overflow = 0.
REQ-034 SHALL, without PIPELINED_DIVMOD_DBZ_EN, omit dbz; results for divisor == 0 are unspecified and not checked.

Structure
REQ-035 SHALL place in shared package divider_pkg: mode encoding constants (MODE_UNSIGNED = 0, MODE_SIGNED = 1) and the latency constant/function DIVIDEND_WIDTH+2.
REQ-036 SHALL use one sub-module, divmod_stage: one restoring iteration (shift, trial subtract, quotient bit, stall enable) instantiated via generate.

Verification
REQ-037 SHALL check, for defaults, signed: dividend = -100, divisor = 7 -> quotient = -14, remainder = -2, overflow = 0, after 18 cycles.
REQ-038 SHALL check unsigned: dividend = 0xFFFF, divisor = 0xFF -> quotient = 0x0101, remainder = 0; and signed with divisor = 0xFF (-1) -> quotient = 1, remainder = 0.
REQ-039 SHALL check signed: dividend = 0x8000, divisor = -1 -> quotient = 0x8000, remainder = 0, overflow = 1.
REQ-040 SHALL check back-to-back: 20 requests with tags 0..19 streamed while out_ready toggles in a 3-low/2-high pattern -> all 20 results in order, correct, none lost or duplicated.
REQ-041 SHALL check reset: reset_n asserted with 5 requests in flight -> out_valid drops immediately, no stale result after release, next request correct after 18 cycles.
REQ-042 SHALL check, with PIPELINED_DIVMOD_DBZ_EN: dividend = 1234, divisor = 0 -> quotient = 0xFFFF, remainder = 1234, dbz = 1.
